hazard_stall_ctrl: RTL and testbench

// - Stall/bubble controller for the 5-stage pipeline; pairs with the forwarding network, which covers every case it does not stall.
// - Keeps a shadow pipeline of destination register and Tnew for the E and M stages, then compares it with the D-stage Tuse.
// - Asserts stall (freezes PC and F/D) and E_clear (injects a bubble into D/E).
// - Optionally times the multiply/divide unit and stalls HI/LO instructions while it is busy.

---
 rtl/hazard_stall_ctrl_pkg.sv | 32 +++
 rtl/hazard_stall_ctrl_mdu_busy_timer.sv | 31 +++
 rtl/hazard_stall_ctrl.sv | 95 +++++++++
 tb/tb_hazard_stall_ctrl.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared encodings, shadow-slot type and hazard compare helpers for hazard_stall_ctrl.
package hazard_stall_ctrl_pkg;

  localparam logic [1:0] TUSE_NONE = 2'd3;
  localparam logic [1:0] TNEW_LINK = 2'd0;
  localparam logic [1:0] TNEW_ALU  = 2'd1;
  localparam logic [1:0] TNEW_LD   = 2'd2;

  typedef enum logic [1:0] {
    MD_NONE = 2'd0,
    MD_MULT = 2'd1,
    MD_DIV  = 2'd2,
    MD_ACC  = 2'd3
  } md_op_e;

  typedef struct packed {
    logic [4:0] a3;
    logic [1:0] tnew;
  } slot_t;

  function automatic logic [1:0] tnew_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  // A TUSE_NONE source can never lose this compare since Tnew tops out at 2.
  function automatic logic src_hazard(input logic [4:0] src, input logic [1:0] tuse,
                                      input slot_t e, input slot_t m);
    return (src != 5'd0) &&
           (((e.a3 == src) && (e.tnew > tuse)) || ((m.a3 == src) && (m.tnew > tuse)));
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_mdu_busy_timer.sv
// Multiply/divide busy counter: reloads when a start sits in the E slot, then counts down.
module mdu_busy_timer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start_e_i,
  input  logic div_e_i,
  output logic md_busy_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start_e_i)
      cnt_d = div_e_i ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    else if (cnt_q != '0)
      cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign md_busy_o = (cnt_q != '0) | start_e_i;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/bubble controller with E/M shadow slots; MDU busy stalling is built only when
// HZD_MDU_EN is defined.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       D_valid,
  input  logic [4:0] D_rs,
  input  logic [4:0] D_rt,
  input  logic [1:0] D_tuse_rs,
  input  logic [1:0] D_tuse_rt,
  input  logic [4:0] D_a3,
  input  logic [1:0] D_tnew,
  input  logic [1:0] D_md_op,
  output logic       stall,
  output logic       E_clear,
  output logic       md_busy
);

  slot_t e_q, e_d, m_q, m_d;
  logic  haz_rs, haz_rt, haz_md, md_busy_w, stall_w;

  assign haz_rs = D_valid & src_hazard(D_rs, D_tuse_rs, e_q, m_q);
  assign haz_rt = D_valid & src_hazard(D_rt, D_tuse_rt, e_q, m_q);

`ifdef HZD_MDU_EN
  logic e_start_q, e_start_d, e_div_q, e_div_d;

  assign e_start_d = D_valid & ~stall_w & ~flush &
                     ((D_md_op == MD_MULT) | (D_md_op == MD_DIV));
  assign e_div_d   = (D_md_op == MD_DIV);

  always_ff @(posedge clk) begin
    if (reset) begin
      e_start_q <= 1'b0;
      e_div_q   <= 1'b0;
    end else begin
      e_start_q <= e_start_d;
      e_div_q   <= e_div_d;
    end
  end

  mdu_busy_timer #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W)
  ) u_mdu_timer (
    .clk      (clk),
    .reset    (reset),
    .start_e_i(e_start_q),
    .div_e_i  (e_div_q),
    .md_busy_o(md_busy_w)
  );

  assign haz_md = D_valid & (D_md_op != MD_NONE) & md_busy_w;
`else
  logic unused_md_op;
  assign unused_md_op = ^D_md_op;
  assign md_busy_w    = 1'b0;
  assign haz_md       = 1'b0;
`endif

  assign stall_w = haz_rs | haz_rt | haz_md;

  // A stalled D instruction must not enter E, so the E slot takes a bubble instead.
  always_comb begin
    e_d = stall_w ? '0 : '{a3: (D_valid ? D_a3 : 5'd0), tnew: D_tnew};
    m_d = '{a3: e_q.a3, tnew: tnew_dec(e_q.tnew)};
    if (flush) begin
      e_d = '0;
      m_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q <= '0;
      m_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
    end
  end

  assign stall   = stall_w & ~reset;
  assign E_clear = stall_w & ~reset;
  assign md_busy = md_busy_w & ~reset;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed scoreboard bench for hazard_stall_ctrl; MDU expectations follow HZD_MDU_EN.
module tb_hazard_stall_ctrl;

`ifdef HZD_MDU_EN
  localparam bit MDU = 1'b1;
`else
  localparam bit MDU = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       flush = 1'b0;
  logic       D_valid = 1'b0;
  logic [4:0] D_rs = 5'd0, D_rt = 5'd0, D_a3 = 5'd0;
  logic [1:0] D_tuse_rs = 2'd3, D_tuse_rt = 2'd3, D_tnew = 2'd0, D_md_op = 2'd0;
  logic       stall, E_clear, md_busy;

  int ncmp = 0;
  int nfail = 0;

  typedef struct {
    string tag;
    logic  stall;
    logic  busy;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .D_valid  (D_valid),
    .D_rs     (D_rs),
    .D_rt     (D_rt),
    .D_tuse_rs(D_tuse_rs),
    .D_tuse_rt(D_tuse_rt),
    .D_a3     (D_a3),
    .D_tnew   (D_tnew),
    .D_md_op  (D_md_op),
    .stall    (stall),
    .E_clear  (E_clear),
    .md_busy  (md_busy)
  );

  // Drive one D-stage cycle, queue the expected outputs, then check them mid-cycle.
  task automatic step(input string tag, input logic v, input logic [4:0] rs,
                      input logic [1:0] tur, input logic [4:0] rt, input logic [1:0] tut,
                      input logic [4:0] a3, input logic [1:0] tn, input logic [1:0] op,
                      input logic fl, input logic rst, input logic es, input logic eb);
    exp_t e;
    @(negedge clk);
    D_valid = v; D_rs = rs; D_tuse_rs = tur; D_rt = rt; D_tuse_rt = tut;
    D_a3 = a3; D_tnew = tn; D_md_op = op; flush = fl; reset = rst;
    sb.push_back('{tag, es, eb & MDU});
    #2;
    e = sb.pop_front();
    ncmp++;
    assert (stall === e.stall) else begin
      nfail++;
      $error("FAIL %s stall got %b exp %b", e.tag, stall, e.stall);
    end
    ncmp++;
    assert (E_clear === e.stall) else begin
      nfail++;
      $error("FAIL %s E_clear got %b exp %b", e.tag, E_clear, e.stall);
    end
    ncmp++;
    assert (md_busy === e.busy) else begin
      nfail++;
      $error("FAIL %s md_busy got %b exp %b", e.tag, md_busy, e.busy);
    end
  endtask

  task automatic nop(input string tag, input logic eb);
    step(tag, 1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, eb);
  endtask

  initial begin
    // reset held, even with a would-be hazard pattern on D
    step("rst0", 1, 5'd8, 2'd0, 5'd0, 2'd3, 5'd8, 2'd2, 2'd3, 0, 1, 0, 0);
    step("rst1", 1, 5'd8, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0, 2'd0, 0, 1, 0, 0);
    nop("idle", 0);

    // load-use on rs
    step("lw8",      1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd8,  2'd2, 2'd0, 0, 0, 0, 0);
    step("lu_stall", 1, 5'd8, 2'd1, 5'd0, 2'd3, 5'd10, 2'd1, 2'd0, 0, 0, 1, 0);
    step("lu_go",    1, 5'd8, 2'd1, 5'd0, 2'd3, 5'd10, 2'd1, 2'd0, 0, 0, 0, 0);
    nop("lu_after", 0);

    // ALU result feeding a branch on rt
    step("addu9",    1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd9, 2'd1, 2'd0, 0, 0, 0, 0);
    step("br_stall", 1, 5'd0, 2'd3, 5'd9, 2'd0, 5'd0, 2'd0, 2'd0, 0, 0, 1, 0);
    step("br_go",    1, 5'd0, 2'd3, 5'd9, 2'd0, 5'd0, 2'd0, 2'd0, 0, 0, 0, 0);
    step("addu9b",   1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd9, 2'd1, 2'd0, 0, 0, 0, 0);
    step("tuse_eq",  1, 5'd0, 2'd3, 5'd9, 2'd1, 5'd0, 2'd0, 2'd0, 0, 0, 0, 0);
    nop("gap", 0);

    // load in M still too young for a tuse-0 reader
    step("lw7",      1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd7, 2'd2, 2'd0, 0, 0, 0, 0);
    nop("lw7_gap", 0);
    step("m_stall",  1, 5'd7, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0, 2'd0, 0, 0, 1, 0);
    step("m_go",     1, 5'd7, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0, 2'd0, 0, 0, 0, 0);

    // $0, TUSE_NONE and invalid D never stall
    step("lw0",      1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd2, 2'd0, 0, 0, 0, 0);
    step("rd_r0",    1, 5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0, 2'd0, 0, 0, 0, 0);
    step("lw5",      1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd5, 2'd2, 2'd0, 0, 0, 0, 0);
    step("tuse3",    1, 5'd5, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 2'd0, 0, 0, 0, 0);
    step("lw5b",     1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd5, 2'd2, 2'd0, 0, 0, 0, 0);
    step("d_inval",  0, 5'd5, 2'd0, 5'd5, 2'd0, 5'd0, 2'd0, 2'd0, 0, 0, 0, 0);
    nop("gap2", 0);

    // flush kills the shadow load
    step("lw8f",     1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd8, 2'd2, 2'd0, 0, 0, 0, 0);
    step("flush",    0, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 2'd0, 1, 0, 0, 0);
    step("post_fl",  1, 5'd8, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0, 2'd0, 0, 0, 0, 0);

    // reset clears the shadow load
    step("lw8r",     1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd8, 2'd2, 2'd0, 0, 0, 0, 0);
    step("rst_mid",  1, 5'd8, 2'd1, 5'd0, 2'd3, 5'd0, 2'd0, 2'd0, 0, 1, 0, 0);
    step("post_rst", 1, 5'd8, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0, 2'd0, 0, 0, 0, 0);
    nop("gap3", 0);

    // div then mflo: 11 stall cycles
    step("div", 1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 2'd2, 0, 0, 0, 0);
    for (int i = 0; i < 11; i++)
      step("mflo_wait", 1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd2, 2'd1, 2'd3, 0, 0, MDU, 1);
    step("mflo_go", 1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd2, 2'd1, 2'd3, 0, 0, 0, 0);
    nop("mflo_e", 0);

    // back-to-back mult: 6 stall cycles
    step("mult1", 1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 2'd1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++)
      step("mult2_wait", 1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 2'd1, 0, 0, MDU, 1);
    step("mult2_go", 1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 2'd1, 0, 0, 0, 0);
    nop("mult2_e", 1);
    for (int i = 0; i < 5; i++) nop("mult2_cnt", 1);
    nop("mult2_done", 0);

    // flush does not abort an in-flight div
    step("div_f", 1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 2'd2, 0, 0, 0, 0);
    nop("div_f_e", 1);
    step("div_flush", 0, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 2'd0, 1, 0, 0, 1);
    for (int i = 0; i < 9; i++) nop("div_f_cnt", 1);
    nop("div_f_done", 0);

    // reset during a div countdown
    step("div_r", 1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 2'd2, 0, 0, 0, 0);
    nop("div_r_e", 1);
    nop("div_r_cnt", 1);
    step("div_rst",  1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd2, 2'd1, 2'd3, 0, 1, 0, 0);
    step("post_drst", 1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd2, 2'd1, 2'd3, 0, 0, 0, 0);
    nop("end", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
